// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data memory responder.
// Contents: FSM state enum, transfer-size constants, size legality / byte-count helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dmem_state_t;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  function automatic logic size_legal(input logic [3:0] size);
    return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) || (size == SZ_D);
  endfunction

  // Byte count actually transferred; anything illegal is treated as a doubleword.
  function automatic logic [3:0] size_bytes(input logic [3:0] size);
    return size_legal(size) ? size : SZ_D;
  endfunction

  function automatic logic [63:0] size_mask(input logic [3:0] nbytes);
    case (nbytes)
      SZ_B:    return 64'h0000_0000_0000_00ff;
      SZ_H:    return 64'h0000_0000_0000_ffff;
      SZ_W:    return 64'h0000_0000_ffff_ffff;
      default: return 64'hffff_ffff_ffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between a load/store initiator and the data memory responder.
// master: initiator side (drives request, consumes response).
// slave:  responder side (accepts request, drives response).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_size;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder_lane_mask.sv
// dmem_lane_mask: combinational byte-enable and misalignment decode.
// Ports:
//   size     - transfer size code (illegal codes treated as 8 bytes)
//   addr_lo  - byte offset within the 8-byte row
//   be       - byte-lane enables within the row
//   misalign - offset is not a multiple of the transfer size
module dmem_lane_mask
  import dmem_pkg::*;
(
  input  logic [3:0] size,
  input  logic [2:0] addr_lo,
  output logic [7:0] be,
  output logic       misalign
);

  logic [3:0] nbytes;
  logic [3:0] nbytes_m1;
  logic [7:0] base;

  always_comb begin
    nbytes    = size_bytes(size);
    nbytes_m1 = nbytes - 4'd1;
    case (nbytes)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0f;
      default: base = 8'hff;
    endcase
    be       = base << addr_lo;
    misalign = |(addr_lo & nbytes_m1[2:0]);
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle byte-addressable data memory behind a valid/ready
// request/response handshake. One request outstanding at a time; the access happens at the
// acceptance edge, the response follows WAIT_CYCLES idle cycles later.
// Ports:
//   clk - clock, rst - asynchronous active-low reset
//   bus - data_mem_responder_if.slave (request in, response out)
// Configuration: define DMEM_RESP_ERR_CHECK_EN to enable size/alignment/range checking and
// rsp_err reporting; otherwise sizes fall back to 8, addresses align down and wrap.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int unsigned AW   = $clog2(DEPTH_BYTES);
  localparam int unsigned ROWS = DEPTH_BYTES / 8;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_t state_q;
  logic [3:0]  cnt_q;
  logic        rsp_valid_q;
  logic [63:0] rdata_q;
  logic        err_q;

  // Storage as ROWS rows of eight byte lanes; deliberately not reset.
  logic [7:0]  mem_q [ROWS][8];

  logic [3:0]    size_eff;
  logic [AW-1:0] addr_eff;
  logic          illegal;
  logic [7:0]    be;
  logic          misalign;
  logic [AW-4:0] row;
  logic [63:0]   wdata_sh;
  logic [63:0]   rd_row;
  logic [63:0]   rd_data;
  logic          accept;
  logic          we;

`ifdef DMEM_RESP_ERR_CHECK_EN
  always_comb begin
    size_eff = bus.req_size;
    addr_eff = bus.req_addr[AW-1:0];
    illegal  = !size_legal(bus.req_size) || misalign || (|bus.req_addr[63:AW]);
  end
`else
  logic unused_addr;

  always_comb begin
    size_eff = size_bytes(bus.req_size);
    addr_eff = bus.req_addr[AW-1:0] & ~AW'(size_eff - 4'd1);
    illegal  = 1'b0;
  end

  assign unused_addr = ^{misalign, bus.req_addr[63:AW]};
`endif

  dmem_lane_mask u_lane_mask (
    .size     (size_eff),
    .addr_lo  (addr_eff[2:0]),
    .be       (be),
    .misalign (misalign)
  );

  assign row      = addr_eff[AW-1:3];
  assign wdata_sh = bus.req_wdata << {addr_eff[2:0], 3'b000};
  assign accept   = (state_q == StIdle) && bus.req_valid;
  assign we       = accept && bus.req_write && !illegal;

  always_comb begin
    rd_row = '0;
    for (int i = 0; i < 8; i++) begin
      rd_row[8*i +: 8] = mem_q[row][i];
    end
    rd_data = (rd_row >> {addr_eff[2:0], 3'b000}) & size_mask(size_eff);
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (be[i]) mem_q[row][i] <= wdata_sh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            rdata_q <= (bus.req_write || illegal) ? 64'd0 : rd_data;
            err_q   <= illegal;
            if (WAIT_CYCLES > 0) begin
              state_q <= StWait;
              cnt_q   <= WAIT_LOAD;
            end else begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a WAIT_CYCLES=2 instance driven by a vector
// table plus reset/backpressure sequences, and a WAIT_CYCLES=0 instance with rsp_ready tied 1.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_responder_if bus ();
  data_mem_responder_if bus0 ();

  data_mem_responder #(.DEPTH_BYTES(1024), .WAIT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  data_mem_responder #(.DEPTH_BYTES(1024), .WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  assign bus0.rsp_ready = 1'b1;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  size;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transaction on the WAIT_CYCLES=2 instance. lat counts rising edges from acceptance
  // (inclusive) up to the edge after which rsp_valid is seen. hold = extra cycles rsp_ready
  // is kept low while the response is checked for stability.
  task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [3:0] size, input int hold,
                        output logic [63:0] rdata, output logic err, output int lat);
    int w;
    rdata = '0;
    err   = 1'b0;
    lat   = 0;
    @(negedge clk);
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) chk("req_ready_timeout", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_size  = size;
    @(posedge clk);
    #1;
    // Scramble request fields: they must only matter at the acceptance edge.
    bus.req_valid = 1'b0;
    bus.req_write = ~wr;
    bus.req_addr  = '1;
    bus.req_wdata = '1;
    bus.req_size  = 4'hf;
    lat = 1;
    w   = 0;
    @(negedge clk);
    while (!bus.rsp_valid && w < 40) begin
      lat++;
      @(negedge clk);
      w++;
    end
    if (w >= 40) chk("rsp_valid_timeout", 64'(bus.rsp_valid), 64'd1);
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_rsp_rdata", bus.rsp_rdata, rdata);
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    logic        seen;
    logic [63:0] zop_addr [4];
    logic [3:0]  zop_size [4];
    logic [63:0] zexp [4];

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_size   = 4'd1;
    bus.rsp_ready  = 1'b0;
    bus0.req_valid = 1'b0;
    bus0.req_write = 1'b0;
    bus0.req_addr  = '0;
    bus0.req_wdata = '0;
    bus0.req_size  = 4'd1;

    // Reset values.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 64'd0);
    chk("reset_rsp_err", 64'(bus.rsp_err), 64'd0);

    // Vector table.
    vecs.push_back('{1'b1, 64'h10, 64'h0123_4567_89AB_CDEF, 4'd8, 64'd0, 1'b0});
    vecs.push_back('{1'b0, 64'h10, 64'd0, 4'd8, 64'h0123_4567_89AB_CDEF, 1'b0});
    vecs.push_back('{1'b1, 64'h11, 64'hAA, 4'd1, 64'd0, 1'b0});
    vecs.push_back('{1'b0, 64'h10, 64'd0, 4'd2, 64'hAAEF, 1'b0});
    vecs.push_back('{1'b0, 64'h17, 64'd0, 4'd1, 64'h01, 1'b0});
    vecs.push_back('{1'b1, 64'h20, 64'h1122_3344_5566_7788, 4'd8, 64'd0, 1'b0});
    vecs.push_back('{1'b1, 64'h22, 64'hCAFE_BEEF, 4'd2, 64'd0, 1'b0});
    vecs.push_back('{1'b0, 64'h20, 64'd0, 4'd4, 64'hBEEF_7788, 1'b0});
    vecs.push_back('{1'b0, 64'h24, 64'd0, 4'd4, 64'h1122_3344, 1'b0});
    vecs.push_back('{1'b1, 64'h1C, 64'hDEAD_BEEF, 4'd4, 64'd0, 1'b0});
    vecs.push_back('{1'b0, 64'h1C, 64'd0, 4'd4, 64'hDEAD_BEEF, 1'b0});
`ifdef DMEM_RESP_ERR_CHECK_EN
    vecs.push_back('{1'b1, 64'h12, 64'hFFFF_FFFF, 4'd4, 64'd0, 1'b1});
    vecs.push_back('{1'b0, 64'h10, 64'd0, 4'd2, 64'hAAEF, 1'b0});
    vecs.push_back('{1'b0, 64'h10, 64'd0, 4'd3, 64'd0, 1'b1});
    vecs.push_back('{1'b0, 64'h400, 64'd0, 4'd1, 64'd0, 1'b1});
    vecs.push_back('{1'b1, 64'h410, 64'h55, 4'd1, 64'd0, 1'b1});
    vecs.push_back('{1'b0, 64'h10, 64'd0, 4'd1, 64'hEF, 1'b0});
`else
    vecs.push_back('{1'b1, 64'h12, 64'h5566_7788, 4'd4, 64'd0, 1'b0});
    vecs.push_back('{1'b0, 64'h10, 64'd0, 4'd8, 64'h0123_4567_5566_7788, 1'b0});
    vecs.push_back('{1'b0, 64'h10, 64'd0, 4'd3, 64'h0123_4567_5566_7788, 1'b0});
    vecs.push_back('{1'b0, 64'h420, 64'd0, 4'd4, 64'hBEEF_7788, 1'b0});
    vecs.push_back('{1'b1, 64'h413, 64'h9999, 4'd2, 64'd0, 1'b0});
    vecs.push_back('{1'b0, 64'h10, 64'd0, 4'd4, 64'h9999_7788, 1'b0});
`endif

    foreach (vecs[i]) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size, 0, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
    end

    // Backpressure: response held 5 cycles, then handshake frees the port next cycle.
    do_req(1'b0, 64'h20, 64'd0, 4'd8, 5, rd, er, lat);
    chk("bp_rdata", rd, 64'h1122_3344_BEEF_7788);
    @(negedge clk);
    chk("bp_req_ready_after", 64'(bus.req_ready), 64'd1);
    chk("bp_rsp_valid_after", 64'(bus.rsp_valid), 64'd0);

    // Reset mid-WAIT after a store: response dropped, store stays committed.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 64'h30;
    bus.req_wdata = 64'h77;
    bus.req_size  = 4'd1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("mid_wait_req_ready", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_mid_rsp_rdata", bus.rsp_rdata, 64'd0);
    bus.rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    bus.rsp_ready = 1'b0;
    chk("rst_mid_no_response", 64'(seen), 64'd0);
    do_req(1'b0, 64'h30, 64'd0, 4'd1, 0, rd, er, lat);
    chk("rst_store_committed", rd, 64'h77);

    // Zero-wait instance, rsp_ready tied 1, request valid held high throughout.
    zop_addr = '{64'h8, 64'h8, 64'h9, 64'hC};
    zop_size = '{4'd8, 4'd8, 4'd1, 4'd4};
    zexp     = '{64'd0, 64'h0F1E_2D3C_4B5A_6978, 64'h69, 64'h0F1E_2D3C};
    @(negedge clk);
    bus0.req_valid = 1'b1;
    bus0.req_write = 1'b1;
    bus0.req_addr  = zop_addr[0];
    bus0.req_wdata = 64'h0F1E_2D3C_4B5A_6978;
    bus0.req_size  = zop_size[0];
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("zw_req_ready_%0d", k), 64'(bus0.req_ready), 64'((k % 2) == 0));
      chk($sformatf("zw_rsp_valid_%0d", k), 64'(bus0.rsp_valid), 64'((k % 2) == 1));
      if ((k % 2) == 1) begin
        chk($sformatf("zw_rdata_%0d", k / 2), bus0.rsp_rdata, zexp[k / 2]);
        if (k < 7) begin
          bus0.req_write = 1'b0;
          bus0.req_addr  = zop_addr[(k + 1) / 2];
          bus0.req_size  = zop_size[(k + 1) / 2];
        end else begin
          bus0.req_valid = 1'b0;
        end
      end
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
